pair_generator: RTL and testbench

PAIR_GENERATOR -- requirements
Module: pair_generator

---
 rtl/md_pkg.sv | 24 ++
 rtl/pair_index_counter.sv | 80 ++++++++
 rtl/pair_generator.sv | 165 ++++++++++++++++
 tb/tb_pair_generator.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md_pkg
//  Description : Shared widths, entry layout and FSM state encoding for the
//                cell-pair generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    localparam int CNT_W       = 8;
    localparam int DATA_W      = 96;
    // One cache entry is {invalid, payload}.
    localparam int ENTRY_W     = DATA_W + 1;
    localparam int INVALID_BIT = DATA_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pair_index_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pair_index_counter
//  Description : Nested reference (i, outer) / neighbor (j, inner) index
//                counters for one cell-pair sweep. Counts and the half-shell
//                mode are captured on load. In half-shell mode j starts at
//                i+1 and the sweep ends as soon as the next row would be
//                empty, so no dead cycles are spent on skipped rows.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                load            - capture counts/mode, restart at first pair
//                advance         - step to the next (i,j); holds when low
//                half            - half-shell mode (only j>i), taken on load
//                ref_count       - reference particle count, taken on load
//                neigh_count     - neighbor particle count, taken on load
//                ref_idx         - current i (registered)
//                neigh_idx       - current j (registered)
//                last            - current (i,j) is the final pair
//  Revision    : 1.0 - initial release
// ============================================================================
module pair_index_counter #(
    parameter int CNT_W = md_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic             half,
    input  logic [CNT_W-1:0] ref_count,
    input  logic [CNT_W-1:0] neigh_count,
    output logic [CNT_W-1:0] ref_idx,
    output logic [CNT_W-1:0] neigh_idx,
    output logic             last
);
    import md_pkg::*;

    logic [CNT_W-1:0] r_ref_cnt;
    logic [CNT_W-1:0] r_neigh_cnt;
    logic [CNT_W-1:0] r_i;
    logic [CNT_W-1:0] r_j;
    logic             r_half;
    logic             w_row_end;
    logic             w_last_row;

    assign w_row_end  = (r_j == r_neigh_cnt - CNT_W'(1));
    // In half-shell mode the row after i is empty exactly when j's last
    // value equals i+1, i.e. this row held a single pair.
    assign w_last_row = (r_i == r_ref_cnt - CNT_W'(1)) ||
                        (r_half && (r_i + CNT_W'(1) == r_j));
    assign last       = w_row_end && w_last_row;

    assign ref_idx    = r_i;
    assign neigh_idx  = r_j;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ref_cnt   <= '0;
            r_neigh_cnt <= '0;
            r_half      <= 1'b0;
            r_i         <= '0;
            r_j         <= '0;
        end else if (load) begin
            r_ref_cnt   <= ref_count;
            r_neigh_cnt <= neigh_count;
            r_half      <= half;
            r_i         <= '0;
            r_j         <= half ? CNT_W'(1) : '0;
        end else if (advance) begin
            if (w_row_end) begin
                // Only reached when another non-empty row follows, so i+2
                // stays below neigh_count and cannot overflow.
                r_i <= r_i + CNT_W'(1);
                r_j <= r_half ? r_i + CNT_W'(2) : '0;
            end else begin
                r_j <= r_j + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pair_generator.sv
`default_nettype none
// ============================================================================
//  Module      : pair_generator
//  Description : Sweeps every (reference, neighbor) particle pair of two cell
//                caches, issuing registered read addresses and emitting the
//                joined entries two cycles later, one pair per cycle.
//                Optional build macro PAIR_HALF_SHELL_EN: when defined and
//                same_cell is latched high, only pairs with j>i are emitted.
//  Ports       : clk, reset               - clock, synchronous active-high reset
//                start                    - begin a sweep (accepted in IDLE)
//                ref_count, neigh_count   - particle counts, latched on start
//                same_cell                - same-cell sweep (half-shell build)
//                stall                    - downstream hold request
//                ref_addr, neigh_addr     - registered cache read addresses
//                ref_rdata, neigh_rdata   - cache data, 1 cycle after address
//                pair_out                 - {neigh entry, ref entry}
//                pair_en                  - pair_out holds a valid pair
//                busy                     - sweep in progress
//                finished                 - one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module pair_generator #(
    parameter int CNT_W  = md_pkg::CNT_W,
    parameter int DATA_W = md_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      ref_count,
    input  logic [CNT_W-1:0]      neigh_count,
    input  logic                  same_cell,
    input  logic                  stall,
    output logic [CNT_W-1:0]      ref_addr,
    output logic [CNT_W-1:0]      neigh_addr,
    input  logic [DATA_W-1:0]     ref_rdata,
    input  logic [DATA_W-1:0]     neigh_rdata,
    output logic [2*DATA_W+1:0]   pair_out,
    output logic                  pair_en,
    output logic                  busy,
    output logic                  finished
);
    import md_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_adv;
    logic              w_last;
    logic              w_half_in;
    logic              w_empty;
    logic              w_addr_v;

    logic              r_rd_v;       // rdata currently holds a pending pair
    logic              r_skid_v;     // that pair was parked in the skid regs
    logic [DATA_W-1:0] r_skid_ref;
    logic [DATA_W-1:0] r_skid_neigh;
    logic [DATA_W-1:0] r_pair_ref;
    logic [DATA_W-1:0] r_pair_neigh;
    logic              r_pair_en;

`ifdef PAIR_HALF_SHELL_EN
    assign w_half_in = same_cell;
`else
    logic unused_same_cell;
    assign unused_same_cell = same_cell;
    assign w_half_in        = 1'b0;
`endif

    // A half-shell sweep with a single neighbor has no j>i pair at all.
    assign w_empty  = (ref_count == '0) || (neigh_count == '0) ||
                      (w_half_in && (neigh_count == CNT_W'(1)));
    assign w_addr_v = (r_state == STREAM);

    pair_index_counter #(
        .CNT_W (CNT_W)
    ) u_index (
        .clk         (clk),
        .reset       (reset),
        .load        (w_accept),
        .advance     (w_adv),
        .half        (w_half_in),
        .ref_count   (ref_count),
        .neigh_count (neigh_count),
        .ref_idx     (ref_addr),
        .neigh_idx   (neigh_addr),
        .last        (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stall freezes the sweep only while pairs are in flight; IDLE and the
    // single FINISH cycle run regardless so finished stays a single pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_empty ? FINISH : STREAM;
                end
            end
            STREAM: begin
                if (!stall) begin
                    if (w_last) begin
                        w_state_nxt = DRAIN;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!stall && !r_rd_v && !r_skid_v) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // While stalled the address is frozen, so the cache keeps returning the
    // data of the frozen address; the pair already sitting on rdata at the
    // first stalled edge would be lost, hence the one-deep skid register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_v       <= 1'b0;
            r_skid_v     <= 1'b0;
            r_skid_ref   <= '0;
            r_skid_neigh <= '0;
            r_pair_ref   <= '0;
            r_pair_neigh <= '0;
            r_pair_en    <= 1'b0;
        end else if (stall) begin
            r_pair_en <= 1'b0;
            if (r_rd_v && !r_skid_v) begin
                r_skid_v     <= 1'b1;
                r_skid_ref   <= ref_rdata;
                r_skid_neigh <= neigh_rdata;
            end
        end else begin
            r_rd_v    <= w_addr_v;
            r_skid_v  <= 1'b0;
            r_pair_en <= r_rd_v;
            if (r_rd_v) begin
                r_pair_ref   <= r_skid_v ? r_skid_ref   : ref_rdata;
                r_pair_neigh <= r_skid_v ? r_skid_neigh : neigh_rdata;
            end
        end
    end

    assign pair_out = {~r_pair_en, r_pair_neigh, ~r_pair_en, r_pair_ref};
    assign pair_en  = r_pair_en;
    assign busy     = (r_state != IDLE);
    assign finished = (r_state == FINISH);

endmodule
`default_nettype wire

// File: tb/tb_pair_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pair_generator
//  Description : Self-checking bench for pair_generator. A table of sweeps
//                (counts, mode, stall window, restart poke) with expected
//                pair count, latency and span; expected pairs go to a queue
//                at start and are popped as pair_en is observed. Extra
//                hand-written sequences cover reset and abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pair_generator;

    localparam int CNT_W  = 8;
    localparam int DATA_W = 96;
    localparam int PAIR_W = 2 * DATA_W + 2;

`ifdef PAIR_HALF_SHELL_EN
    localparam bit HALF_EN = 1'b1;
`else
    localparam bit HALF_EN = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic [CNT_W-1:0]  ref_count;
    logic [CNT_W-1:0]  neigh_count;
    logic              same_cell;
    logic              stall;
    logic [CNT_W-1:0]  ref_addr;
    logic [CNT_W-1:0]  neigh_addr;
    logic [DATA_W-1:0] ref_rdata;
    logic [DATA_W-1:0] neigh_rdata;
    logic [PAIR_W-1:0] pair_out;
    logic              pair_en;
    logic              busy;
    logic              finished;

    pair_generator #(
        .CNT_W  (CNT_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ref_count   (ref_count),
        .neigh_count (neigh_count),
        .same_cell   (same_cell),
        .stall       (stall),
        .ref_addr    (ref_addr),
        .neigh_addr  (neigh_addr),
        .ref_rdata   (ref_rdata),
        .neigh_rdata (neigh_rdata),
        .pair_out    (pair_out),
        .pair_en     (pair_en),
        .busy        (busy),
        .finished    (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] ref_word(input logic [CNT_W-1:0] k);
        return {24'hA1B2C3, k, 32'h0F1E2D3C ^ {24'h0, k}, 24'h00FF00, ~k};
    endfunction

    function automatic logic [DATA_W-1:0] neigh_word(input logic [CNT_W-1:0] k);
        return {24'h5A6B7C, k, 32'h13572468 ^ {k, 24'h0}, 24'h990011, k};
    endfunction

    // Synchronous cache models: data one cycle after the address.
    always @(posedge clk) begin
        ref_rdata   <= ref_word(ref_addr);
        neigh_rdata <= neigh_word(neigh_addr);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk_bits(input string name, input logic [PAIR_W-1:0] act, input logic [PAIR_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard and per-sweep statistics.
    logic [PAIR_W-1:0] exp_q[$];
    bit mon_en    = 1'b0;
    int n_pairs   = 0;
    int n_fin     = 0;
    int busy_cyc  = 0;
    int first_cyc = -1;
    int last_cyc  = -1;
    int fin_cyc   = -1;

    always @(negedge clk) begin : monitor
        logic [PAIR_W-1:0] e;
        if (mon_en) begin
            if (busy) busy_cyc++;
            if (finished) begin
                n_fin++;
                fin_cyc = cyc;
            end
            if (pair_en) begin
                if (n_pairs == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_pairs++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pair_unexpected actual=%h required=none (cycle %0d)", pair_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk_bits("pair_data", pair_out, e);
                end
            end else begin
                chk_int("invalid_bits", {30'd0, pair_out[PAIR_W-1], pair_out[DATA_W]}, 3);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_pairs   = 0;
        n_fin     = 0;
        busy_cyc  = 0;
        first_cyc = -1;
        last_cyc  = -1;
        fin_cyc   = -1;
    endtask

    typedef struct {
        int rc;
        int nc;
        bit sc;
        int stall_at;   // cycle offset from start when stall rises
        int stall_len;  // number of stalled edges
        bit poke;       // re-pulse start with other counts mid-sweep
        int exp_pairs;
        int exp_lat;    // start cycle to first pair_en
        int exp_span;   // first to last pair_en, inclusive
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic run_vec(input int idx, input vec_t v);
        int t0;
        int rel;
        bit half;
        half = HALF_EN && v.sc;
        for (int i = 0; i < v.rc; i++) begin
            for (int j = (half ? i + 1 : 0); j < v.nc; j++) begin
                exp_q.push_back({1'b0, neigh_word(CNT_W'(j)), 1'b0, ref_word(CNT_W'(i))});
            end
        end
        clear_stats();
        tick();
        ref_count   = CNT_W'(v.rc);
        neigh_count = CNT_W'(v.nc);
        same_cell   = v.sc;
        start       = 1'b1;
        t0          = cyc;
        tick();
        start = 1'b0;
        if (v.exp_pairs > 0) begin
            chk_int($sformatf("v%0d_first_ref_addr", idx), int'(ref_addr), 0);
            chk_int($sformatf("v%0d_first_neigh_addr", idx), int'(neigh_addr), half ? 1 : 0);
        end
        for (int k = 0; k < v.exp_pairs + 60; k++) begin
            tick();
            rel   = cyc - t0;
            stall = (rel >= v.stall_at) && (rel < v.stall_at + v.stall_len);
            if (v.poke) begin
                if (rel == 5) begin
                    start       = 1'b1;
                    ref_count   = CNT_W'(1);
                    neigh_count = CNT_W'(7);
                    same_cell   = ~v.sc;
                end else begin
                    start = 1'b0;
                end
            end
            if (n_fin > 0 && cyc >= fin_cyc + 2) break;
        end
        stall = 1'b0;
        start = 1'b0;
        chk_int($sformatf("v%0d_finished_count", idx), n_fin, 1);
        chk_int($sformatf("v%0d_pair_count", idx), n_pairs, v.exp_pairs);
        chk_int($sformatf("v%0d_scoreboard_left", idx), exp_q.size(), 0);
        chk_int($sformatf("v%0d_busy_end", idx), int'(busy), 0);
        if (v.exp_pairs > 0) begin
            chk_int($sformatf("v%0d_latency", idx), first_cyc - t0, v.exp_lat);
            chk_int($sformatf("v%0d_span", idx), last_cyc - first_cyc + 1, v.exp_span);
            chk_int($sformatf("v%0d_finish_after_last", idx), fin_cyc - last_cyc, 1);
        end else begin
            chk_int($sformatf("v%0d_busy_short", idx),
                    int'(busy_cyc >= 1 && busy_cyc <= 2), 1);
        end
        exp_q.delete();
    endtask

    logic [PAIR_W-1:0] rst_out;
    int                t0;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        stall       = 1'b0;
        same_cell   = 1'b0;
        ref_count   = '0;
        neigh_count = '0;
        rst_out     = '0;
        rst_out[PAIR_W-1] = 1'b1;
        rst_out[DATA_W]   = 1'b1;

        //          rc   nc  sc  st_at len poke pairs                     lat span
        vecs[0]  = '{3,   2,  0,  0,   0,  0,   6,                        3,  6};
        vecs[1]  = '{0,   5,  0,  0,   0,  0,   0,                        3,  0};
        vecs[2]  = '{3,   0,  0,  0,   0,  0,   0,                        3,  0};
        vecs[3]  = '{3,   3,  0,  4,   4,  0,   9,                        3,  13};
        vecs[4]  = '{4,   4,  1,  0,   0,  0,   HALF_EN ? 6 : 16,         3,  HALF_EN ? 6 : 16};
        vecs[5]  = '{2,   3,  1,  0,   0,  0,   HALF_EN ? 3 : 6,          3,  HALF_EN ? 3 : 6};
        vecs[6]  = '{3,   3,  0,  0,   0,  1,   9,                        3,  9};
        vecs[7]  = '{1,   1,  0,  0,   0,  0,   1,                        3,  1};
        vecs[8]  = '{255, 1,  0,  0,   0,  0,   255,                      3,  255};
        vecs[9]  = '{1,   255,0,  0,   0,  0,   255,                      3,  255};
        vecs[10] = '{3,   1,  1,  0,   0,  0,   HALF_EN ? 0 : 3,          3,  3};
        vecs[11] = '{5,   3,  1,  0,   0,  0,   HALF_EN ? 3 : 15,         3,  HALF_EN ? 3 : 15};
        vecs[12] = '{2,   3,  0,  3,   2,  0,   6,                        3,  8};
        vecs[13] = '{2,   2,  0,  2,   3,  0,   4,                        6,  4};

        repeat (3) tick();
        chk_int("reset_pair_en", int'(pair_en), 0);
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_finished", int'(finished), 0);
        chk_int("reset_ref_addr", int'(ref_addr), 0);
        chk_int("reset_neigh_addr", int'(neigh_addr), 0);
        chk_bits("reset_pair_out", pair_out, rst_out);
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int n = 0; n < NV; n++) begin
            run_vec(n, vecs[n]);
        end

        // Reset after the 3rd pair of a 4x4 sweep aborts it outright.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                exp_q.push_back({1'b0, neigh_word(CNT_W'(j)), 1'b0, ref_word(CNT_W'(i))});
            end
        end
        clear_stats();
        tick();
        ref_count   = CNT_W'(4);
        neigh_count = CNT_W'(4);
        same_cell   = 1'b0;
        start       = 1'b1;
        t0          = cyc;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20 && (cyc - t0) < 5; k++) tick();
        chk_int("abort_pairs_before", n_pairs, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_int("abort_pair_en", int'(pair_en), 0);
        chk_bits("abort_pair_out", pair_out, rst_out);
        chk_int("abort_busy", int'(busy), 0);
        chk_int("abort_ref_addr", int'(ref_addr), 0);
        exp_q.delete();
        repeat (10) tick();
        chk_int("abort_pairs_after", n_pairs, 3);
        chk_int("abort_no_finished", n_fin, 0);

        // A fresh start after the abort runs a complete sweep.
        run_vec(99, '{4, 4, 0, 0, 0, 0, 16, 3, 16});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
